// File: rtl/lutram_readback_checker.sv
// Readback checker for a LUTRAM write/read test: compares SPO/DPO samples against
// an address-bit pattern, counts mismatches, and reports sticky pass/fail status.
module lutram_readback_checker #(
  parameter int A_WIDTH     = 6,
  parameter int PATTERN_BIT = 0,
  parameter bit INVERT      = 1'b0,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 valid_i,
  input  logic [A_WIDTH-1:0]   addr_i,
  input  logic                 spo_i,
  input  logic                 dpo_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic                 first_err_valid_o,
  output logic [A_WIDTH-1:0]   first_err_addr_o,
  output logic [1:0]           first_err_port_o,
  output logic                 seq_err_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [A_WIDTH-1:0]   idx_q;
  logic [CNT_WIDTH-1:0] err_count_q;
  logic                 first_err_valid_q;
  logic [A_WIDTH-1:0]   first_err_addr_q;
  logic [1:0]           first_err_port_q;
  logic                 seq_err_q;

  logic exp_bit;
  logic spo_bad;
  logic dpo_bad;
  logic any_bad;
  logic accept;
  logic last_sample;

  // valid_i has no back-pressure: a sample is consumed in the cycle valid_i is
  // high, but only while checking and not in the same cycle as a restart.
  assign accept      = valid_i && (state_q == ST_CHECK) && !start_i;
  assign exp_bit     = addr_i[PATTERN_BIT] ^ INVERT;
  assign spo_bad     = (spo_i != exp_bit);
  assign dpo_bad     = (dpo_i != exp_bit);
  assign any_bad     = spo_bad || dpo_bad;
  assign last_sample = accept && (idx_q == {A_WIDTH{1'b1}});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (start_i)          state_d = ST_CHECK;
        else if (last_sample) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start_i) state_d = ST_CHECK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o            = (state_q == ST_CHECK);
    done_o            = (state_q == ST_DONE);
    pass_o            = (state_q == ST_DONE) && (err_count_q == '0) && !seq_err_q;
    err_count_o       = err_count_q;
    first_err_valid_o = first_err_valid_q;
    first_err_addr_o  = first_err_addr_q;
    first_err_port_o  = first_err_port_q;
    seq_err_o         = seq_err_q;
    state_o           = state_q;
  end

  // start_i clears status from any state, so a held start behaves as repeated restarts.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      idx_q             <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_addr_q  <= '0;
      first_err_port_q  <= 2'b00;
      seq_err_q         <= 1'b0;
    end else if (accept) begin
      idx_q <= idx_q + 1'b1;
      if (any_bad && (err_count_q != {CNT_WIDTH{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
      if (any_bad && !first_err_valid_q) begin
        first_err_valid_q <= 1'b1;
        first_err_addr_q  <= addr_i;
        first_err_port_q  <= {dpo_bad, spo_bad};
      end
      if (addr_i != idx_q) begin
        seq_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Directed bench for lutram_readback_checker: a default instance plus a 4-bit
// counter instance share stimulus so saturation can be observed.
module tb_lutram_readback_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [5:0] addr;
  logic       spo;
  logic       dpo;

  logic       busy_a, done_a, pass_a, fev_a, seq_a;
  logic [7:0] cnt_a;
  logic [5:0] fea_a;
  logic [1:0] fep_a, st_a;

  logic       busy_b, done_b, pass_b, fev_b, seq_b;
  logic [3:0] cnt_b;
  logic [5:0] fea_b;
  logic [1:0] fep_b, st_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lutram_readback_checker #(.A_WIDTH(6), .PATTERN_BIT(0), .INVERT(1'b0), .CNT_WIDTH(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .addr_i(addr),
    .spo_i(spo), .dpo_i(dpo), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_count_o(cnt_a), .first_err_valid_o(fev_a), .first_err_addr_o(fea_a),
    .first_err_port_o(fep_a), .seq_err_o(seq_a), .state_o(st_a)
  );

  lutram_readback_checker #(.A_WIDTH(6), .PATTERN_BIT(0), .INVERT(1'b0), .CNT_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid), .addr_i(addr),
    .spo_i(spo), .dpo_i(dpo), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_count_o(cnt_b), .first_err_valid_o(fev_b), .first_err_addr_o(fea_b),
    .first_err_port_o(fep_b), .seq_err_o(seq_b), .state_o(st_b)
  );

  task automatic send(input logic [5:0] a, input logic s, input logic d);
    @(negedge clk);
    start = 1'b0; valid = 1'b1; addr = a; spo = s; dpo = d;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; valid = 1'b0; addr = '0; spo = 1'b0; dpo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if ({busy_a, done_a, pass_a, fev_a, seq_a} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {busy_a, done_a, pass_a, fev_a, seq_a}); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a); end
    total++; if ({fea_a, fep_a} !== 8'd0) begin bad++; $display("FAIL reset_first got=%h exp=0", {fea_a, fep_a}); end
    total++; if (st_a !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st_a); end
  endtask

  task automatic test_clean_run();
    pulse_start();
    total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL clean_busy_run got=%b exp=1", busy_a); end
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      send(a, a[0], a[0]);
    end
    idle_cycle();
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL clean_done got=%b exp=1", done_a); end
    total++; if (pass_a !== 1'b1) begin bad++; $display("FAIL clean_pass got=%b exp=1", pass_a); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL clean_cnt got=%0d exp=0", cnt_a); end
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL clean_busy got=%b exp=0", busy_a); end
  endtask

  task automatic test_single_fault();
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      send(a, a[0], (i == 37) ? ~a[0] : a[0]);
    end
    idle_cycle();
    total++; if (cnt_a !== 8'd1) begin bad++; $display("FAIL fault_cnt got=%0d exp=1", cnt_a); end
    total++; if (fev_a !== 1'b1) begin bad++; $display("FAIL fault_fev got=%b exp=1", fev_a); end
    total++; if (fea_a !== 6'd37) begin bad++; $display("FAIL fault_addr got=%0d exp=37", fea_a); end
    total++; if (fep_a !== 2'b10) begin bad++; $display("FAIL fault_port got=%b exp=10", fep_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL fault_pass got=%b exp=0", pass_a); end
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL fault_done got=%b exp=1", done_a); end
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      send(a, ~a[0], a[0]);
    end
    idle_cycle();
    total++; if (cnt_b !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", cnt_b); end
    total++; if (fea_b !== 6'd0) begin bad++; $display("FAIL sat_addr got=%0d exp=0", fea_b); end
    total++; if (fep_b !== 2'b01) begin bad++; $display("FAIL sat_port got=%b exp=01", fep_b); end
    total++; if (cnt_a !== 8'd64) begin bad++; $display("FAIL sat_cnt8 got=%0d exp=64", cnt_a); end
    total++; if (done_b !== 1'b1 || pass_b !== 1'b0) begin bad++; $display("FAIL sat_status got=%b%b exp=10", done_b, pass_b); end
  endtask

  task automatic test_seq_error();
    pulse_start();
    for (int i = 0; i < 63; i++) begin
      logic [5:0] a;
      a = (i == 10) ? 6'd11 : 6'(i);
      send(a, a[0], a[0]);
    end
    idle_cycle();
    total++; if (done_a !== 1'b0 || busy_a !== 1'b1) begin bad++; $display("FAIL seq_early got=%b%b exp=01", done_a, busy_a); end
    send(6'd63, 1'b1, 1'b1);
    idle_cycle();
    total++; if (seq_a !== 1'b1) begin bad++; $display("FAIL seq_flag got=%b exp=1", seq_a); end
    total++; if (cnt_a !== 8'd0) begin bad++; $display("FAIL seq_cnt got=%0d exp=0", cnt_a); end
    total++; if (pass_a !== 1'b0) begin bad++; $display("FAIL seq_pass got=%b exp=0", pass_a); end
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL seq_done got=%b exp=1", done_a); end
  endtask

  task automatic test_restart_gaps();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      logic [5:0] a;
      a = 6'(i);
      send(a, (i == 3) ? ~a[0] : a[0], a[0]);
    end
    idle_cycle();
    total++; if (cnt_a !== 8'd1 || fea_a !== 6'd3) begin bad++; $display("FAIL restart_pre got=%0d/%0d exp=1/3", cnt_a, fea_a); end
    pulse_start();
    total++; if (cnt_a !== 8'd0 || fev_a !== 1'b0 || busy_a !== 1'b1) begin bad++; $display("FAIL restart_clear got=%0d/%b/%b exp=0/0/1", cnt_a, fev_a, busy_a); end
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      send(a, a[0], a[0]);
      repeat ((i % 3) + 1) idle_cycle();
    end
    total++; if (cnt_a !== 8'd0 || fev_a !== 1'b0) begin bad++; $display("FAIL gaps_err got=%0d/%b exp=0/0", cnt_a, fev_a); end
    total++; if (pass_a !== 1'b1 || done_a !== 1'b1) begin bad++; $display("FAIL gaps_pass got=%b%b exp=11", pass_a, done_a); end
    send(6'd5, 1'b0, 1'b0);
    idle_cycle();
    total++; if (cnt_a !== 8'd0 || pass_a !== 1'b1) begin bad++; $display("FAIL done_ignore got=%0d/%b exp=0/1", cnt_a, pass_a); end
  endtask

  task automatic test_reset_midrun();
    pulse_start();
    for (int i = 0; i < 30; i++) begin
      logic [5:0] a;
      a = 6'(i);
      send(a, ~a[0], a[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    total++; if ({busy_a, done_a, pass_a, fev_a, seq_a} !== 5'b0 || cnt_a !== 8'd0) begin bad++; $display("FAIL midrst_out got=%b cnt=%0d exp=00000 cnt=0", {busy_a, done_a, pass_a, fev_a, seq_a}, cnt_a); end
    total++; if (st_a !== 2'd0 || fea_a !== 6'd0 || fep_a !== 2'b00) begin bad++; $display("FAIL midrst_state got=%0d/%0d/%b exp=0/0/00", st_a, fea_a, fep_a); end
    for (int i = 0; i < 4; i++) begin
      logic [5:0] a;
      a = 6'(i);
      send(a, ~a[0], ~a[0]);
    end
    idle_cycle();
    total++; if (cnt_a !== 8'd0 || busy_a !== 1'b0) begin bad++; $display("FAIL idle_ignore got=%0d/%b exp=0/0", cnt_a, busy_a); end
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total++; if (st_a !== 2'd0 || busy_a !== 1'b0) begin bad++; $display("FAIL rst_wins got=%0d/%b exp=0/0", st_a, busy_a); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_single_fault();
    test_saturation();
    test_seq_error();
    test_restart_gaps();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
